// File: rtl/blob_bbox_tracker_if.sv
// Pixel-stream input and frame-result handshake between the median stage,
// the bbox tracker and the register-side consumer.
interface blob_bbox_tracker_if;
    logic        Cam_enable_in;
    logic [9:0]  CamHsync_count_in;
    logic [10:0] CamPix_count_in;
    logic [15:0] data_in;
    logic        result_ack;
    logic        result_valid;
    logic        result_overrun;
    logic        obj_found;
    logic [10:0] bbox_xmin;
    logic [10:0] bbox_xmax;
    logic [9:0]  bbox_ymin;
    logic [9:0]  bbox_ymax;
    logic [21:0] pix_total;
    logic [31:0] sum_x;
    logic [31:0] sum_y;

    modport master (
        output Cam_enable_in, CamHsync_count_in, CamPix_count_in, data_in, result_ack,
        input  result_valid, result_overrun, obj_found, bbox_xmin, bbox_xmax,
               bbox_ymin, bbox_ymax, pix_total, sum_x, sum_y
    );

    modport slave (
        input  Cam_enable_in, CamHsync_count_in, CamPix_count_in, data_in, result_ack,
        output result_valid, result_overrun, obj_found, bbox_xmin, bbox_xmax,
               bbox_ymin, bbox_ymax, pix_total, sum_x, sum_y
    );
endinterface

// File: rtl/blob_bbox_tracker.sv
// Per-frame foreground statistics (bbox, count, coordinate sums) on the binary
// pixel stream, latched at each frame boundary behind a valid/ack handshake.
module blob_bbox_tracker #(
    parameter int unsigned MIN_PIXELS = 16,
    parameter int unsigned DATA_BIT   = 15
) (
    input logic                  clk,
    input logic                  reset,
    blob_bbox_tracker_if.slave   bus
);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e      state_q;
    logic [9:0]  prev_hsync_q;
    logic [10:0] acc_xmin_q, acc_xmax_q;
    logic [9:0]  acc_ymin_q, acc_ymax_q;
    logic [21:0] acc_cnt_q;
    logic [31:0] acc_sx_q, acc_sy_q;

    logic [10:0] px;
    logic [9:0]  py;
    logic        fg, boundary, latch, ack_ok, acc_empty;
    logic [10:0] seed_xmin, seed_xmax;
    logic [9:0]  seed_ymin, seed_ymax;
    logic [21:0] seed_cnt;
    logic [31:0] seed_sx, seed_sy;

    always_comb begin
        px        = bus.CamPix_count_in;
        py        = bus.CamHsync_count_in;
        fg        = bus.Cam_enable_in & bus.data_in[DATA_BIT];
        boundary  = bus.Cam_enable_in && (py < prev_hsync_q);
        latch     = boundary && (state_q == StAccum);
        ack_ok    = bus.result_ack && bus.result_valid;
        acc_empty = (acc_cnt_q == 22'd0);
        // The boundary pixel opens the new frame, so seed the accumulators with it.
        seed_xmin = fg ? px : 11'h7ff;
        seed_xmax = fg ? px : 11'd0;
        seed_ymin = fg ? py : 10'h3ff;
        seed_ymax = fg ? py : 10'd0;
        seed_cnt  = fg ? 22'd1 : 22'd0;
        seed_sx   = fg ? {21'd0, px} : 32'd0;
        seed_sy   = fg ? {22'd0, py} : 32'd0;
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q            <= StIdle;
            prev_hsync_q       <= 10'd0;
            acc_xmin_q         <= 11'h7ff;
            acc_xmax_q         <= 11'd0;
            acc_ymin_q         <= 10'h3ff;
            acc_ymax_q         <= 10'd0;
            acc_cnt_q          <= 22'd0;
            acc_sx_q           <= 32'd0;
            acc_sy_q           <= 32'd0;
            bus.result_valid   <= 1'b0;
            bus.result_overrun <= 1'b0;
            bus.obj_found      <= 1'b0;
            bus.bbox_xmin      <= 11'd0;
            bus.bbox_xmax      <= 11'd0;
            bus.bbox_ymin      <= 10'd0;
            bus.bbox_ymax      <= 10'd0;
            bus.pix_total      <= 22'd0;
            bus.sum_x          <= 32'd0;
            bus.sum_y          <= 32'd0;
        end else begin
            if (bus.Cam_enable_in) begin
                prev_hsync_q <= py;
            end

            if (boundary) begin
                state_q    <= StAccum;
                acc_xmin_q <= seed_xmin;
                acc_xmax_q <= seed_xmax;
                acc_ymin_q <= seed_ymin;
                acc_ymax_q <= seed_ymax;
                acc_cnt_q  <= seed_cnt;
                acc_sx_q   <= seed_sx;
                acc_sy_q   <= seed_sy;
            end else if (fg && state_q == StAccum) begin
                if (px < acc_xmin_q) acc_xmin_q <= px;
                if (px > acc_xmax_q) acc_xmax_q <= px;
                if (py < acc_ymin_q) acc_ymin_q <= py;
                if (py > acc_ymax_q) acc_ymax_q <= py;
                acc_cnt_q <= acc_cnt_q + 22'd1;
                acc_sx_q  <= acc_sx_q + {21'd0, px};
                acc_sy_q  <= acc_sy_q + {22'd0, py};
            end

            if (latch) begin
                // An empty frame reports a zero box rather than the min/max sentinels.
                bus.bbox_xmin <= acc_empty ? 11'd0 : acc_xmin_q;
                bus.bbox_xmax <= acc_empty ? 11'd0 : acc_xmax_q;
                bus.bbox_ymin <= acc_empty ? 10'd0 : acc_ymin_q;
                bus.bbox_ymax <= acc_empty ? 10'd0 : acc_ymax_q;
                bus.pix_total <= acc_cnt_q;
                bus.sum_x     <= acc_sx_q;
                bus.sum_y     <= acc_sy_q;
                bus.obj_found <= (acc_cnt_q >= 22'(MIN_PIXELS));
            end

            if (latch) begin
                bus.result_valid <= 1'b1;
            end else if (ack_ok) begin
                bus.result_valid <= 1'b0;
            end

            if (latch && bus.result_valid && !bus.result_ack) begin
                bus.result_overrun <= 1'b1;
            end else if (ack_ok) begin
                bus.result_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blob_bbox_tracker.sv
// Directed-plus-random bench for blob_bbox_tracker against a pixel-list reference model.
module tb_blob_bbox_tracker;

    logic clk = 1'b0;
    logic reset = 1'b1;

    blob_bbox_tracker_if bus ();

    blob_bbox_tracker #(
        .MIN_PIXELS (16),
        .DATA_BIT   (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: foreground pixel list of the current frame plus expected outputs.
    bit     m_active;
    int     m_prev_y;
    int     fx[$];
    int     fy[$];
    bit     e_valid, e_ovr, e_found;
    int     e_xmin, e_xmax, e_ymin, e_ymax, e_cnt;
    longint e_sx, e_sy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("result_valid",   32'(bus.result_valid),   32'(e_valid));
        chk("result_overrun", 32'(bus.result_overrun), 32'(e_ovr));
        chk("obj_found",      32'(bus.obj_found),      32'(e_found));
        chk("bbox_xmin",      32'(bus.bbox_xmin),      32'(e_xmin));
        chk("bbox_xmax",      32'(bus.bbox_xmax),      32'(e_xmax));
        chk("bbox_ymin",      32'(bus.bbox_ymin),      32'(e_ymin));
        chk("bbox_ymax",      32'(bus.bbox_ymax),      32'(e_ymax));
        chk("pix_total",      32'(bus.pix_total),      32'(e_cnt));
        chk("sum_x",          bus.sum_x,               32'(e_sx));
        chk("sum_y",          bus.sum_y,               32'(e_sy));
    endtask

    task automatic model_clear();
        m_active = 0;
        m_prev_y = 0;
        fx.delete();
        fy.delete();
        e_valid = 0; e_ovr = 0; e_found = 0;
        e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_cnt = 0;
        e_sx = 0; e_sy = 0;
    endtask

    task automatic model_latch();
        e_cnt = fx.size();
        e_sx = 0;
        e_sy = 0;
        e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
        if (e_cnt > 0) begin
            e_xmin = 2047; e_ymin = 1023;
        end
        foreach (fx[i]) begin
            e_sx += fx[i];
            e_sy += fy[i];
            if (fx[i] < e_xmin) e_xmin = fx[i];
            if (fx[i] > e_xmax) e_xmax = fx[i];
            if (fy[i] < e_ymin) e_ymin = fy[i];
            if (fy[i] > e_ymax) e_ymax = fy[i];
        end
        e_found = (e_cnt >= 16);
    endtask

    task automatic model_step(input bit rst, input bit en, input int y, input int x,
                              input bit fg, input bit ack);
        bit old_v;
        bit latched;
        if (rst) begin
            model_clear();
            return;
        end
        latched = 0;
        old_v = e_valid;
        if (en) begin
            if (y < m_prev_y) begin
                if (m_active) begin
                    model_latch();
                    latched = 1;
                end
                m_active = 1;
                fx.delete();
                fy.delete();
            end
            if (m_active && fg) begin
                fx.push_back(x);
                fy.push_back(y);
            end
            m_prev_y = y;
        end
        if (ack && old_v) begin
            e_valid = 0;
            e_ovr = 0;
        end
        if (latched) begin
            if (old_v && !ack) e_ovr = 1;
            e_valid = 1;
        end
    endtask

    // One pipeline cycle: check outputs of everything applied so far, then drive.
    task automatic step(input bit rst, input bit en, input int y, input int x,
                        input bit fg, input bit ack);
        @(posedge clk);
        check_all();
        reset = rst;
        bus.Cam_enable_in = en;
        bus.CamHsync_count_in = 10'(y);
        bus.CamPix_count_in = 11'(x);
        bus.data_in = {fg, 15'($urandom)};
        bus.result_ack = ack;
        model_step(rst, en, y, x, fg, ack);
    endtask

    task automatic idle(input bit ack);
        step(0, 0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 2047)), 1, ack);
    endtask

    task automatic line(input int y, input int x0, input int x1,
                        input int pfg, input int pen, input int pack);
        for (int x = x0; x <= x1; x++) begin
            bit en;
            en = ($urandom % 100) < pen;
            step(0, en, en ? y : int'($urandom % 1024), x,
                 ($urandom % 100) < pfg, ($urandom % 100) < pack);
        end
    endtask

    task automatic rand_frame(input int nlines, input int pack);
        int y0;
        y0 = int'($urandom_range(0, 2));
        for (int y = y0; y < y0 + nlines; y++) begin
            line(y * 3, 200, 200 + int'($urandom_range(8, 23)), 40, 85, pack);
        end
    endtask

    initial begin
        model_clear();
        bus.Cam_enable_in = 0;
        bus.CamHsync_count_in = 0;
        bus.CamPix_count_in = 0;
        bus.data_in = 0;
        bus.result_ack = 0;
        repeat (2) @(negedge clk);
        step(1, 1, 7, 7, 1, 0);

        // Partial frame after reset is discarded.
        for (int y = 5; y <= 9; y++) line(y, 0, 15, 50, 100, 0);

        // Rectangle X=100..109, Y=20..24.
        step(0, 1, 0, 0, 0, 0);
        for (int y = 18; y <= 26; y++) begin
            for (int x = 96; x <= 113; x++) begin
                step(0, 1, y, x, (x >= 100 && x <= 109 && y >= 20 && y <= 24), 0);
            end
        end
        step(0, 1, 0, 0, 0, 0);
        idle(0);
        chk("rect_valid", 32'(bus.result_valid), 1);
        chk("rect_xmin", 32'(bus.bbox_xmin), 100);
        chk("rect_xmax", 32'(bus.bbox_xmax), 109);
        chk("rect_ymin", 32'(bus.bbox_ymin), 20);
        chk("rect_ymax", 32'(bus.bbox_ymax), 24);
        chk("rect_total", 32'(bus.pix_total), 50);
        chk("rect_sum_x", bus.sum_x, 5225);
        chk("rect_sum_y", bus.sum_y, 1100);
        chk("rect_found", 32'(bus.obj_found), 1);

        // Ack drops valid.
        idle(1);
        idle(0);
        chk("ack_valid", 32'(bus.result_valid), 0);

        // Small frame: 3 foreground pixels.
        for (int y = 1; y <= 3; y++) begin
            for (int x = 0; x <= 7; x++) step(0, 1, y, x, (x == 2), 0);
        end
        step(0, 1, 0, 0, 0, 0);
        idle(0);
        chk("small_found", 32'(bus.obj_found), 0);
        chk("small_total", 32'(bus.pix_total), 3);

        // Empty frame, latched without ack: overrun.
        for (int y = 1; y <= 4; y++) line(y, 0, 7, 0, 100, 0);
        step(0, 1, 0, 0, 0, 0);
        idle(0);
        chk("empty_total", 32'(bus.pix_total), 0);
        chk("empty_xmin", 32'(bus.bbox_xmin), 0);
        chk("empty_ymin", 32'(bus.bbox_ymin), 0);
        chk("empty_valid", 32'(bus.result_valid), 1);
        chk("empty_overrun", 32'(bus.result_overrun), 1);
        idle(1);
        idle(0);
        chk("ack_overrun", 32'(bus.result_overrun), 0);
        chk("ack2_valid", 32'(bus.result_valid), 0);

        // Latch, then next latch with ack in the same cycle.
        for (int y = 1; y <= 5; y++) line(y, 10, 25, 50, 100, 0);
        step(0, 1, 0, 0, 1, 0);
        for (int y = 1; y <= 5; y++) line(y, 10, 25, 50, 100, 0);
        step(0, 1, 0, 0, 0, 1);
        idle(0);
        chk("simul_valid", 32'(bus.result_valid), 1);
        chk("simul_overrun", 32'(bus.result_overrun), 0);
        idle(1);

        // Enable gating: only odd X are enabled, all foreground.
        for (int y = 1; y <= 3; y++) begin
            for (int x = 0; x <= 15; x++) begin
                step(0, x % 2, (x % 2) ? y : int'($urandom % 1024), x, 1, 0);
            end
        end
        step(0, 1, 0, 0, 0, 0);
        idle(0);
        chk("gate_total", 32'(bus.pix_total), 24);

        // Random frames with random enable and ack.
        for (int f = 0; f < 6; f++) rand_frame(int'($urandom_range(4, 8)), 5);

        // Mid-frame reset, then recovery over the next boundaries.
        for (int y = 1; y <= 3; y++) line(y, 0, 15, 50, 100, 0);
        step(1, 1, 0, 0, 1, 0);
        idle(0);
        chk("rst_valid", 32'(bus.result_valid), 0);
        for (int y = 5; y <= 7; y++) line(y, 0, 15, 50, 100, 0);
        for (int f = 0; f < 3; f++) rand_frame(5, 0);
        step(0, 1, 0, 0, 0, 0);
        idle(0);
        idle(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
